// File: rtl/mc_model_queued.sv
// Queued behavioural memory-controller model: per-entry latency, bounded request queue, in-order 8-byte responses.
// Optional macro MC_MODEL_STALL_INJECT_EN adds LFSR-driven request-stall and issue-block injection.
module mc_model_queued #(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int RAM_DEPTH       = 512,
    parameter int LATENCY         = 4,
    parameter int QUEUE_DEPTH     = 8,
    parameter int STALL_MARGIN    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mc_rq_vld,
    input  logic [2:0]                   mc_rq_cmd,
    input  logic [3:0]                   mc_rq_scmd,
    input  logic [47:0]                  mc_rq_vadr,
    input  logic [1:0]                   mc_rq_size,
    input  logic [MC_RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
    input  logic [63:0]                  mc_rq_data,
    input  logic                         mc_rq_flush,
    output logic                         mc_rq_stall,
    output logic                         mc_rs_vld,
    output logic [2:0]                   mc_rs_cmd,
    output logic [3:0]                   mc_rs_scmd,
    output logic [MC_RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
    output logic [63:0]                  mc_rs_data,
    input  logic                         mc_rs_stall,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

    localparam int PW    = $clog2(QUEUE_DEPTH);
    localparam int CW    = PW + 1;
    localparam int WORDS = RAM_DEPTH / 8;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [2:0] AEMC_CMD_RD8      = 3'd1;
    localparam logic [2:0] AEMC_CMD_WR8      = 3'd2;
    localparam logic [2:0] MCAE_CMD_RD8_DATA = 3'd2;
    localparam logic [2:0] MCAE_CMD_WR_CMP   = 3'd3;

    localparam logic [CW-1:0] FULL_CNT  = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] STALL_THR = CW'(QUEUE_DEPTH - STALL_MARGIN);
    localparam logic [7:0]    AGE_SAT   = 8'(LATENCY);
    localparam logic [7:0]    ISSUE_AGE = 8'(LATENCY - 1);
    localparam logic [47:0]   ADDR_LIM  = 48'(RAM_DEPTH);

    typedef struct packed {
        logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
        logic [1:0]                 size;
        logic [47:0]                vadr;
        logic [3:0]                 scmd;
        logic [2:0]                 cmd;
        logic [63:0]                data;
    } entry_t;

    entry_t        q   [QUEUE_DEPTH];
    logic [7:0]    age [QUEUE_DEPTH];
    logic [63:0]   mem [WORDS];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    entry_t        head, rq_entry;
    logic          empty, full, push, pop, overflow;
    logic          head_oor, head_bad, mem_we;
    logic [AW-1:0] head_idx;
    logic [2:0]    rsp_cmd;
    logic [63:0]   rsp_data;
    logic          issue_blk, inject_stall;

    // Diagnostic sticky flags; the simulator-facing model reports through these.
    logic          overflow_err, range_err, cmd_err, flush_seen;

`ifdef MC_MODEL_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign inject_stall = (lfsr[1:0] == 2'b00);
    assign issue_blk    = (lfsr[3:2] == 2'b00);
`else
    assign inject_stall = 1'b0;
    assign issue_blk    = 1'b0;
`endif

    assign rq_entry = '{rtnctl: mc_rq_rtnctl, size: mc_rq_size, vadr: mc_rq_vadr,
                        scmd: mc_rq_scmd, cmd: mc_rq_cmd, data: mc_rq_data};
    assign head      = q[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign pop       = !empty && (age[rd_ptr] >= ISSUE_AGE) && !mc_rs_stall && !issue_blk;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push      = mc_rq_vld && (!full || pop);
    assign overflow  = mc_rq_vld && full && !pop;
    assign occupancy = count;

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CW'(1);
        else if (!push && pop) count_nxt = count - CW'(1);
    end

    always_comb begin
        rsp_cmd  = '0;
        rsp_data = '0;
        mem_we   = 1'b0;
        head_bad = 1'b1;
        head_oor = (head.vadr >= ADDR_LIM);
        head_idx = head.vadr[3 +: AW];
        if (head.size == 2'b11 && head.cmd == AEMC_CMD_WR8) begin
            head_bad = 1'b0;
            rsp_cmd  = MCAE_CMD_WR_CMP;
            mem_we   = pop && !head_oor && reset;
        end else if (head.size == 2'b11 && head.cmd == AEMC_CMD_RD8) begin
            head_bad = 1'b0;
            rsp_cmd  = MCAE_CMD_RD8_DATA;
            rsp_data = head_oor ? 64'h0 : mem[head_idx];
        end
    end

    // Queue payload and backing array are not reset; only pointers, count and ages are.
    always_ff @(posedge clk) begin
        if (reset && push) q[wr_ptr] <= rq_entry;
        if (mem_we)        mem[head_idx] <= head.data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mc_rq_stall  <= 1'b0;
            mc_rs_vld    <= 1'b0;
            mc_rs_cmd    <= '0;
            mc_rs_scmd   <= '0;
            mc_rs_rtnctl <= '0;
            mc_rs_data   <= '0;
            overflow_err <= 1'b0;
            range_err    <= 1'b0;
            cmd_err      <= 1'b0;
            flush_seen   <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (push && wr_ptr == PW'(i)) age[i] <= '0;
                else if (age[i] < AGE_SAT)    age[i] <= age[i] + 8'd1;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count       <= count_nxt;
            mc_rq_stall <= (count_nxt >= STALL_THR) || inject_stall;
            // A stalled consumer freezes the whole response register.
            if (!mc_rs_stall) begin
                mc_rs_vld    <= pop;
                mc_rs_cmd    <= pop ? rsp_cmd : 3'd0;
                mc_rs_scmd   <= pop ? head.scmd : 4'd0;
                mc_rs_rtnctl <= pop ? head.rtnctl : '0;
                mc_rs_data   <= pop ? rsp_data : 64'h0;
            end
            overflow_err <= overflow_err | overflow;
            range_err    <= range_err | (push && mc_rq_vadr >= ADDR_LIM);
            cmd_err      <= cmd_err | (pop && head_bad);
            flush_seen   <= flush_seen | mc_rq_flush;
        end
    end

endmodule

// File: tb/tb_mc_model_queued.sv
// Self-checking bench for mc_model_queued: vector table, latency, stall hold, overflow, random traffic, reset flush.
module tb_mc_model_queued;

    localparam int TW = 32;
    localparam logic [2:0] C_RD8 = 3'd1;
    localparam logic [2:0] C_WR8 = 3'd2;
    localparam logic [2:0] R_RD8 = 3'd2;
    localparam logic [2:0] R_CMP = 3'd3;
    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D2 = 64'hA5A50F0FDEADBEEF;
    localparam logic [63:0] D3 = 64'hFFFF000012345678;
    localparam logic [63:0] D4 = 64'h0123456789ABCDEF;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [3:0]    scmd;
        logic [TW-1:0] tag;
        logic [63:0]   data;
    } rsp_t;
    localparam int RW = $bits(rsp_t);

    typedef struct {
        logic [2:0]    cmd;
        logic [1:0]    size;
        logic [47:0]   vadr;
        logic [63:0]   data;
        logic [TW-1:0] tag;
        logic [2:0]    exp_cmd;
        logic [63:0]   exp_data;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          rq_vld, rq_flush, rq_stall, rs_vld, rs_stall;
    logic [2:0]    rq_cmd, rs_cmd;
    logic [3:0]    rq_scmd, rs_scmd;
    logic [47:0]   rq_vadr;
    logic [1:0]    rq_size;
    logic [TW-1:0] rq_rtnctl, rs_rtnctl;
    logic [63:0]   rq_data, rs_data;
    logic [3:0]    occupancy;

    logic          r7_rq_vld, r7_rq_stall, r7_rs_vld, r7_rs_stall;
    logic [2:0]    r7_rq_cmd, r7_rs_cmd;
    logic [3:0]    r7_rq_scmd, r7_rs_scmd;
    logic [47:0]   r7_rq_vadr;
    logic [TW-1:0] r7_rq_rtnctl, r7_rs_rtnctl;
    logic [63:0]   r7_rq_data, r7_rs_data;
    logic [3:0]    r7_occupancy;

    mc_model_queued u_dut (
        .clk(clk), .reset(reset),
        .mc_rq_vld(rq_vld), .mc_rq_cmd(rq_cmd), .mc_rq_scmd(rq_scmd), .mc_rq_vadr(rq_vadr),
        .mc_rq_size(rq_size), .mc_rq_rtnctl(rq_rtnctl), .mc_rq_data(rq_data), .mc_rq_flush(rq_flush),
        .mc_rq_stall(rq_stall), .mc_rs_vld(rs_vld), .mc_rs_cmd(rs_cmd), .mc_rs_scmd(rs_scmd),
        .mc_rs_rtnctl(rs_rtnctl), .mc_rs_data(rs_data), .mc_rs_stall(rs_stall), .occupancy(occupancy)
    );

    mc_model_queued #(.LATENCY(7)) u_dut7 (
        .clk(clk), .reset(reset),
        .mc_rq_vld(r7_rq_vld), .mc_rq_cmd(r7_rq_cmd), .mc_rq_scmd(r7_rq_scmd), .mc_rq_vadr(r7_rq_vadr),
        .mc_rq_size(2'b11), .mc_rq_rtnctl(r7_rq_rtnctl), .mc_rq_data(r7_rq_data), .mc_rq_flush(1'b0),
        .mc_rq_stall(r7_rq_stall), .mc_rs_vld(r7_rs_vld), .mc_rs_cmd(r7_rs_cmd), .mc_rs_scmd(r7_rs_scmd),
        .mc_rs_rtnctl(r7_rs_rtnctl), .mc_rs_data(r7_rs_data), .mc_rs_stall(r7_rs_stall), .occupancy(r7_occupancy)
    );

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [63:0]   model_mem [8];
    logic          hold_pending = 1'b0;
    rsp_t          held;
    vec_t          vecs [14];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t act, exp;
        act = '{cmd: rs_cmd, scmd: rs_scmd, tag: rs_rtnctl, data: rs_data};
        if (reset !== 1'b1) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (!rs_vld || act !== held) begin
                    errors++;
                    $display("FAIL hold: got vld=%0b %h expected vld=1 %h", rs_vld, act, held);
                end
            end
            hold_pending = rs_vld && rs_stall;
            held = act;
            if (rs_vld && !rs_stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got tag %0d expected no response", rs_rtnctl);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL rsp: got %h expected %h", act, exp);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] cmd, input logic [1:0] size, input logic [47:0] vadr,
                        input logic [63:0] data, input logic [TW-1:0] tag, input logic [3:0] scmd,
                        input logic expect_rsp, input logic [2:0] ecmd, input logic [63:0] edata);
        rsp_t r;
        r.cmd = ecmd; r.scmd = scmd; r.tag = tag; r.data = edata;
        if (expect_rsp) exp_q.push_back(r);
        rq_vld = 1'b1; rq_cmd = cmd; rq_size = size; rq_vadr = vadr;
        rq_data = data; rq_rtnctl = tag; rq_scmd = scmd;
        @(posedge clk); #1;
        rq_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n, saw;
        int k;
        logic [63:0] d;

        vecs[0]  = '{C_WR8, 2'b11, 48'h040, D1, 5,  R_CMP, 64'h0};
        vecs[1]  = '{C_RD8, 2'b11, 48'h040, 0,  6,  R_RD8, D1};
        vecs[2]  = '{C_WR8, 2'b11, 48'h1F8, D2, 7,  R_CMP, 64'h0};
        vecs[3]  = '{C_RD8, 2'b11, 48'h1F8, 0,  8,  R_RD8, D2};
        vecs[4]  = '{C_RD8, 2'b11, 48'h044, 0,  9,  R_RD8, D1};
        vecs[5]  = '{C_WR8, 2'b11, 48'h000, D4, 10, R_CMP, 64'h0};
        vecs[6]  = '{C_WR8, 2'b11, 48'h200, D3, 11, R_CMP, 64'h0};
        vecs[7]  = '{C_RD8, 2'b11, 48'h000, 0,  12, R_RD8, D4};
        vecs[8]  = '{C_RD8, 2'b11, 48'h200, 0,  13, R_RD8, 64'h0};
        vecs[9]  = '{3'd6,  2'b11, 48'h040, 0,  14, 3'd0,  64'h0};
        vecs[10] = '{C_RD8, 2'b10, 48'h040, 0,  15, 3'd0,  64'h0};
        vecs[11] = '{C_RD8, 2'b11, 48'hFFFF_FFFF_0040, 0, 16, R_RD8, 64'h0};
        vecs[12] = '{C_WR8, 2'b10, 48'h040, D3, 17, 3'd0,  64'h0};
        vecs[13] = '{C_RD8, 2'b11, 48'h040, 0,  18, R_RD8, D1};

        reset = 1'b0; rq_vld = 1'b0; rq_flush = 1'b0; rs_stall = 1'b0;
        rq_cmd = '0; rq_scmd = '0; rq_vadr = '0; rq_size = 2'b11; rq_rtnctl = '0; rq_data = '0;
        r7_rq_vld = 1'b0; r7_rq_cmd = '0; r7_rq_scmd = '0; r7_rq_vadr = '0;
        r7_rq_rtnctl = '0; r7_rq_data = '0; r7_rs_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vld", 128'(rs_vld), 0);
        check("reset_rq_stall", 128'(rq_stall), 0);
        check("reset_payload", {rs_cmd, rs_scmd, rs_rtnctl, rs_data}, 0);
        check("reset_occ", 128'(occupancy), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven back-to-back traffic.
        for (int i = 0; i < 14; i++)
            send(vecs[i].cmd, vecs[i].size, vecs[i].vadr, vecs[i].data, vecs[i].tag, 4'(i),
                 1'b1, vecs[i].exp_cmd, vecs[i].exp_data);
        wait_drain("table_drain", 60);

        // Latency: default build.
        send(C_RD8, 2'b11, 48'h040, 0, 40, 4'h1, 1'b1, R_RD8, D1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rs_vld && n < 20);
        check("latency4", 128'(n), 4);
        @(posedge clk); #1;
        check("one_cycle4", 128'(rs_vld), 0);

        // Latency: LATENCY=7 instance.
        r7_rq_vld = 1'b1; r7_rq_cmd = C_WR8; r7_rq_vadr = 48'h8; r7_rq_data = D2;
        r7_rq_rtnctl = 33; r7_rq_scmd = 4'h3;
        @(posedge clk); #1;
        r7_rq_vld = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!r7_rs_vld && n < 20);
        check("latency7", 128'(n), 7);
        check("lat7_payload", {r7_rs_cmd, r7_rs_scmd, r7_rs_rtnctl, r7_rs_data}, {R_CMP, 4'h3, 32'd33, 64'h0});
        @(posedge clk); #1;
        check("one_cycle7", 128'(r7_rs_vld), 0);

        // Response stall held for 3 cycles while a response is valid.
        send(C_RD8, 2'b11, 48'h040, 0, 200, 4'h2, 1'b1, R_RD8, D1);
        send(C_RD8, 2'b11, 48'h1F8, 0, 201, 4'h3, 1'b1, R_RD8, D2);
        send(C_RD8, 2'b11, 48'h000, 0, 202, 4'h4, 1'b1, R_RD8, D4);
        n = 0;
        while (!rs_vld && n < 20) begin @(posedge clk); #1; n++; end
        rs_stall = 1'b1;
        check("stall_first_tag", 128'(rs_rtnctl), 200);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_hold_vld", 128'(rs_vld), 1);
            check("stall_hold_tag", 128'(rs_rtnctl), 200);
            check("stall_hold_data", 128'(rs_data), 128'(D1));
        end
        rs_stall = 1'b0;
        wait_drain("stall_drain", 40);

        // Overflow: ten requests into a stalled queue of eight.
        rs_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(C_RD8, 2'b11, 48'h040, 0, TW'(100 + i), 4'(i), (i < 8), R_RD8, D1);
            check("ovf_occ", 128'(occupancy), 128'((i + 1 < 8) ? i + 1 : 8));
            check("ovf_rq_stall", 128'(rq_stall), 128'(i + 1 >= 6));
        end
        rs_stall = 1'b0;
        wait_drain("ovf_drain", 40);
        check("ovf_empty", 128'(occupancy), 0);

        // Random traffic over eight words with random consumer stall.
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            model_mem[i] = d;
            send(C_WR8, 2'b11, 48'h100 + 48'(8 * i), d, TW'(300 + i), 4'h5, 1'b1, R_CMP, 64'h0);
        end
        wait_drain("init_drain", 40);
        for (int i = 0; i < 60; i++) begin
            rs_stall = ($urandom_range(0, 3) == 0);
            if (!rq_stall && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) begin
                    d = {$urandom, $urandom};
                    model_mem[k] = d;
                    send(C_WR8, 2'b11, 48'h100 + 48'(8 * k), d, TW'(400 + i), 4'h6, 1'b1, R_CMP, 64'h0);
                end else begin
                    send(C_RD8, 2'b11, 48'h100 + 48'(8 * k) + 48'($urandom_range(0, 7)), 0,
                         TW'(400 + i), 4'h7, 1'b1, R_RD8, model_mem[k]);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        rs_stall = 1'b0;
        wait_drain("rand_drain", 200);

        // Reset with three entries queued: no stale responses afterwards.
        for (int i = 0; i < 3; i++)
            send(C_RD8, 2'b11, 48'h100, 0, TW'(500 + i), 4'h8, 1'b1, R_RD8, model_mem[0]);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        check("rst_occ", 128'(occupancy), 0);
        check("rst_vld", 128'(rs_vld), 0);
        check("rst_rq_stall", 128'(rq_stall), 0);
        check("rst_payload", {rs_cmd, rs_scmd, rs_rtnctl, rs_data}, 0);
        check("rst7_state", {r7_occupancy, r7_rq_stall, r7_rs_vld}, 0);
        saw = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rs_vld) saw++;
        end
        check("rst_no_stale", 128'(saw), 0);
        check("rst_occ_after", 128'(occupancy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
